pwm_duty_sequencer: RTL and testbench

//  Controller that sequences the PWM generator in Top: owns its duty word and clock-divider N.

---
 rtl/pwm_pkg.sv | 40 ++++
 rtl/pwm_level_counter.sv | 33 +++
 rtl/pwm_duty_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM duty sequencer.
//   R, NW     : duty resolution and divider width
//   CW        : level counter width
//   MODE_*    : sequencing profile encodings
//   state_e   : controller states
//   dir_e     : triangle sweep direction
//   cfg_t     : duty/divider payload held in the shadow registers
package pwm_pkg;

    localparam int unsigned R  = 6;
    localparam int unsigned NW = 12;
    localparam int unsigned CW = 12;

    localparam logic [R-1:0] DUTY_MAX = '1;

    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_RAMP = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef struct packed {
        logic [R-1:0]  duty;
        logic [NW-1:0] n;
    } cfg_t;

    // A divider of zero would stall the PWM, so it is forced to one.
    function automatic logic [NW-1:0] coerce_n(input logic [NW-1:0] n);
        return (n == '0) ? NW'(1) : n;
    endfunction

endpackage

// File: rtl/pwm_level_counter.sv
// Counts period_end pulses within one duty level.
//   clk, reset : clock, async active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : advance by one, wrapping to zero after LAST
//   last_c     : combinational flag, count is at LAST
module pwm_level_counter
    import pwm_pkg::*;
#(
    parameter int unsigned LAST = 35
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic last_c
);

    logic [CW-1:0] count;

    assign last_c = (count == CW'(LAST));

    // Level position register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last_c ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Sequences the duty word and divider of a PWM generator through
// hold / sawtooth / triangle profiles, updating only at period boundaries.
//   clk, reset  : clock, async active-low reset
//   enable      : run the sequence (0 = idle, outputs frozen)
//   mode        : 0 hold, 1 ramp, 2 triangle, 3 hold
//   duty_set    : duty value to load
//   n_set       : divider value to load (0 is treated as 1)
//   cfg_load    : capture duty_set/n_set into the shadow registers
//   period_end  : pulse at the last tick of each PWM period
//   duty_out    : duty word to the PWM
//   n_out       : divider to the PWM
//   busy        : high while running
//   step_done   : one-cycle pulse when a level completes
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned STEPS_PER_LEVEL = 36,
    parameter int unsigned DUTY_STEP       = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [R-1:0]  duty_set,
    input  logic [NW-1:0] n_set,
    input  logic          cfg_load,
    input  logic          period_end,
    output logic [R-1:0]  duty_out,
    output logic [NW-1:0] n_out,
    output logic          busy,
    output logic          step_done
);

    localparam logic [R-1:0] STEP_R  = R'(DUTY_STEP);
    localparam logic [R:0]   STEP_R1 = (R+1)'(DUTY_STEP);

    state_e        state, state_next;
    dir_e          dir, dir_next, lvl_dir;
    cfg_t          shadow, shadow_next;
    logic          pending, pending_next;
    logic [R-1:0]  duty_next, lvl_duty;
    logic [NW-1:0] n_next;
    logic          busy_next, step_done_next;
    logic          cnt_clr, cnt_inc, cnt_last_c;
    logic          apply;
    logic [R:0]    sum_up;

    pwm_level_counter #(
        .LAST (STEPS_PER_LEVEL - 1)
    ) u_level_counter (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .last_c (cnt_last_c)
    );

    // Duty value and direction for the next level under the current mode
    always_comb begin
        lvl_duty = duty_out;
        lvl_dir  = dir;
        sum_up   = {1'b0, duty_out} + STEP_R1;
        case (mode)
            MODE_RAMP: lvl_duty = sum_up[R-1:0];
            MODE_TRI: begin
                if (dir == DIR_UP) begin
                    if (sum_up >= {1'b0, DUTY_MAX}) begin
                        lvl_duty = DUTY_MAX;
                        lvl_dir  = DIR_DOWN;
                    end else begin
                        lvl_duty = sum_up[R-1:0];
                    end
                end else begin
                    if (duty_out <= STEP_R) begin
                        lvl_duty = '0;
                        lvl_dir  = DIR_UP;
                    end else begin
                        lvl_duty = duty_out - STEP_R;
                    end
                end
            end
            default: ;
        endcase
    end

    // Next-state, shadow and output logic
    always_comb begin
        state_next     = state;
        dir_next       = dir;
        shadow_next    = shadow;
        pending_next   = pending;
        duty_next      = duty_out;
        n_next         = n_out;
        step_done_next = 1'b0;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        // A fresh cfg_load replaces the pending shadow before it can be applied.
        apply          = pending && !cfg_load;

        case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (apply) begin
                    duty_next    = shadow.duty;
                    n_next       = shadow.n;
                    pending_next = 1'b0;
                end
                if (enable) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    cnt_clr    = 1'b1;
                end else if (period_end) begin
                    if (apply) begin
                        duty_next    = shadow.duty;
                        n_next       = shadow.n;
                        pending_next = 1'b0;
                        dir_next     = DIR_UP;
                        cnt_clr      = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                        if (cnt_last_c) begin
                            step_done_next = 1'b1;
                            duty_next      = lvl_duty;
                            dir_next       = lvl_dir;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (cfg_load) begin
            shadow_next.duty = duty_set;
            shadow_next.n    = coerce_n(n_set);
            pending_next     = 1'b1;
        end

        busy_next = (state_next == ST_RUN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            dir       <= DIR_UP;
            shadow    <= '0;
            pending   <= 1'b0;
            duty_out  <= '0;
            n_out     <= NW'(1);
            busy      <= 1'b0;
            step_done <= 1'b0;
        end else begin
            state     <= state_next;
            dir       <= dir_next;
            shadow    <= shadow_next;
            pending   <= pending_next;
            duty_out  <= duty_next;
            n_out     <= n_next;
            busy      <= busy_next;
            step_done <= step_done_next;
        end
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer: directed scenarios with
// constant expectations plus a randomized run against a behavioural model.
module tb_pwm_duty_sequencer;

    localparam int SPL   = 4;
    localparam int STEP  = 1;
    localparam int DMAX  = 63;
    localparam int PE_N  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [5:0]  duty_set = '0;
    logic [11:0] n_set = '0;
    logic        cfg_load = 1'b0;
    logic        period_end = 1'b0;
    logic [5:0]  duty_out;
    logic [11:0] n_out;
    logic        busy;
    logic        step_done;

    int n_cmp = 0;
    int n_err = 0;
    int tick = 0;
    int sd_count = 0;

    pwm_duty_sequencer #(
        .STEPS_PER_LEVEL (SPL),
        .DUTY_STEP       (STEP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .duty_set   (duty_set),
        .n_set      (n_set),
        .cfg_load   (cfg_load),
        .period_end (period_end),
        .duty_out   (duty_out),
        .n_out      (n_out),
        .busy       (busy),
        .step_done  (step_done)
    );

    always #5 clk = ~clk;

    // Behavioural reference: levels counted in whole periods, duty as an integer.
    int m_duty = 0, m_n = 1, m_dir = 1, m_periods = 0, m_sd = 0, m_sn = 1;
    bit m_run = 0, m_pend = 0, m_busy = 0, m_step = 0, m_take;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_duty = 0; m_n = 1; m_dir = 1; m_periods = 0;
            m_sd = 0; m_sn = 1; m_run = 0; m_pend = 0; m_busy = 0; m_step = 0;
        end else begin
            m_take = m_pend && !cfg_load;
            m_step = 0;
            if (!m_run) begin
                if (m_take) begin m_duty = m_sd; m_n = m_sn; m_pend = 0; end
                m_periods = 0;
                m_run = enable;
            end else if (!enable) begin
                m_run = 0;
                m_periods = 0;
            end else if (period_end) begin
                if (m_take) begin
                    m_duty = m_sd; m_n = m_sn; m_pend = 0; m_periods = 0; m_dir = 1;
                end else begin
                    m_periods++;
                    if (m_periods == SPL) begin
                        m_periods = 0;
                        m_step = 1;
                        if (mode == 2'd1) begin
                            m_duty = (m_duty + STEP) % (DMAX + 1);
                        end else if (mode == 2'd2) begin
                            if (m_dir > 0) begin
                                m_duty = m_duty + STEP;
                                if (m_duty >= DMAX) begin m_duty = DMAX; m_dir = -1; end
                            end else begin
                                if (m_duty <= STEP) begin m_duty = 0; m_dir = 1; end
                                else m_duty = m_duty - STEP;
                            end
                        end
                    end
                end
            end
            if (cfg_load) begin
                m_sd = int'(duty_set);
                m_sn = (n_set == 12'd0) ? 1 : int'(n_set);
                m_pend = 1;
            end
            m_busy = m_run;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: period_end on every PE_N-th tick, compare against the model after the edge.
    task automatic tick_clk();
        period_end = ((tick % PE_N) == PE_N - 1);
        @(posedge clk);
        @(negedge clk);
        tick++;
        cfg_load = 1'b0;
        if (step_done) sd_count++;
        check_eq("m_duty", int'(duty_out), m_duty);
        check_eq("m_n", int'(n_out), m_n);
        check_eq("m_busy", int'(busy), int'(m_busy));
        check_eq("m_step", int'(step_done), int'(m_step));
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) tick_clk();
    endtask

    task automatic run_to_pe();
        while ((tick % PE_N) != PE_N - 1) tick_clk();
    endtask

    task automatic one_pe();
        run_to_pe();
        tick_clk();
    endtask

    task automatic load(input int d, input int n);
        duty_set = 6'(d);
        n_set    = 12'(n);
        cfg_load = 1'b1;
        tick_clk();
    endtask

    int sd0;
    int exp_seq[$];

    initial begin
        #2 reset = 1'b0;
        @(negedge clk);
        run(3);
        check_eq("rst_duty", int'(duty_out), 0);
        check_eq("rst_n", int'(n_out), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_step", int'(step_done), 0);

        // Reset mid-run, then restart
        reset = 1'b1;
        tick_clk();
        load(33, 9);
        tick_clk();
        check_eq("idle_load_duty", int'(duty_out), 33);
        check_eq("idle_load_n", int'(n_out), 9);
        enable = 1'b1;
        run(10);
        check_eq("run_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check_eq("async_duty", int'(duty_out), 0);
        check_eq("async_n", int'(n_out), 1);
        check_eq("async_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        check_eq("pre_busy", int'(busy), 0);
        tick_clk();
        check_eq("busy_rise", int'(busy), 1);

        // Sawtooth wrap
        mode = 2'd1;
        load(62, 5);
        one_pe();
        check_eq("ramp_load", int'(duty_out), 62);
        sd_count = 0;
        for (int i = 0; i < 3; i++) one_pe();
        check_eq("ramp_mid", int'(duty_out), 62);
        check_eq("ramp_mid_sd", sd_count, 0);
        one_pe();
        check_eq("ramp_63", int'(duty_out), 63);
        check_eq("ramp_sd1", sd_count, 1);
        for (int i = 0; i < 4; i++) one_pe();
        check_eq("ramp_wrap", int'(duty_out), 0);
        check_eq("ramp_sd2", sd_count, 2);

        // Triangle from 61 up, down to 0 and back up
        mode = 2'd2;
        load(61, 5);
        one_pe();
        check_eq("tri_load", int'(duty_out), 61);
        exp_seq = '{62, 63, 62, 61};
        for (int v = 60; v >= 0; v--) exp_seq.push_back(v);
        exp_seq.push_back(1);
        foreach (exp_seq[i]) begin
            for (int j = 0; j < SPL; j++) one_pe();
            check_eq("tri_seq", int'(duty_out), exp_seq[i]);
        end

        // Shadow load mid-level in RUN with n_set=0
        mode = 2'd0;
        run(3);
        load(10, 0);
        check_eq("sh_hold_duty", int'(duty_out), 1);
        check_eq("sh_hold_n", int'(n_out), 5);
        run_to_pe();
        check_eq("sh_pre_pe", int'(duty_out), 1);
        tick_clk();
        check_eq("sh_duty", int'(duty_out), 10);
        check_eq("sh_n_coerced", int'(n_out), 1);
        mode = 2'd1;
        sd0 = sd_count;
        for (int i = 0; i < 3; i++) one_pe();
        check_eq("sh_restart_duty", int'(duty_out), 10);
        check_eq("sh_restart_sd", sd_count - sd0, 0);
        one_pe();
        check_eq("sh_level_duty", int'(duty_out), 11);
        check_eq("sh_level_sd", sd_count - sd0, 1);

        // cfg_load coincident with period_end
        run_to_pe();
        duty_set = 6'd40; n_set = 12'd7; cfg_load = 1'b1;
        tick_clk();
        check_eq("coin_old_duty", int'(duty_out), 11);
        check_eq("coin_old_n", int'(n_out), 1);
        one_pe();
        check_eq("coin_new_duty", int'(duty_out), 40);
        check_eq("coin_new_n", int'(n_out), 7);

        // Stop mid-level, then load in IDLE
        load(20, 3);
        one_pe();
        check_eq("stop_load", int'(duty_out), 20);
        run(3);
        enable = 1'b0;
        tick_clk();
        check_eq("stop_busy", int'(busy), 0);
        check_eq("stop_duty", int'(duty_out), 20);
        sd0 = sd_count;
        run(40);
        check_eq("idle_no_sd", sd_count - sd0, 0);
        check_eq("idle_duty", int'(duty_out), 20);
        load(5, 3);
        tick_clk();
        check_eq("idle_apply", int'(duty_out), 5);

        // Randomized run against the model
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (enable ? ($urandom_range(199) == 0) : ($urandom_range(19) == 0))
                enable = ~enable;
            if ($urandom_range(49) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(29) == 0) begin
                duty_set = 6'($urandom_range(63));
                n_set    = ($urandom_range(3) == 0) ? 12'd0 : 12'($urandom_range(4095));
                cfg_load = 1'b1;
            end
            if ($urandom_range(399) == 0) begin
                reset = 1'b0;
                tick_clk();
                reset = 1'b1;
            end else begin
                tick_clk();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
